// File: rtl/count_pkg.sv
// -----------------------------------------------------------------------------
// count_pkg
//   Encodings and helpers shared by count_updn and the tops that instantiate it.
//   - dir_e  : value of the 'up' input   (DIR_UP = increment, DIR_DN = decrement)
//   - mode_e : value of the 'sat' input  (MODE_SAT = saturate, MODE_WRAP = wrap)
//   - digits_for(maxval) : smallest number of decimal digits that can show
//     every value 0..maxval, for sizing the DIGITS parameter.
// -----------------------------------------------------------------------------
package count_pkg;

    typedef enum logic {
        DIR_DN = 1'b0,
        DIR_UP = 1'b1
    } dir_e;

    typedef enum logic {
        MODE_WRAP = 1'b0,
        MODE_SAT  = 1'b1
    } mode_e;

    function automatic int digits_for(input int maxval);
        int n;
        int lim;
        n   = 1;
        lim = 10;
        while (lim <= maxval) begin
            n   = n + 1;
            lim = lim * 10;
        end
        return n;
    endfunction

endpackage

// File: rtl/bin2bcd_n.sv
// -----------------------------------------------------------------------------
// bin2bcd_n
//   Combinational double-dabble: binary value -> packed BCD digits.
//   Parameters: WIDTH  - width of the binary input
//               DIGITS - number of BCD digits produced (must cover the range)
//   Ports:      bin [WIDTH-1:0]     binary input
//               bcd [4*DIGITS-1:0]  decimal digits, digit 0 in bcd[3:0]
// -----------------------------------------------------------------------------
module bin2bcd_n #(
    parameter int WIDTH  = 8,
    parameter int DIGITS = 3
) (
    input  logic [WIDTH-1:0]    bin,
    output logic [4*DIGITS-1:0] bcd
);

    logic [4*DIGITS-1:0] work;

    always_comb begin
        // NOTE: blocking assignments here on purpose -- each shift/add-3 pass
        // must see the result of the previous one within the same evaluation.
        work = '0;
        for (int i = WIDTH - 1; i >= 0; i--) begin
            // Any digit >= 5 would overflow past 9 when doubled; pre-add 3.
            for (int d = 0; d < DIGITS; d++) begin
                if (work[4*d +: 4] >= 4'd5) begin
                    work[4*d +: 4] = work[4*d +: 4] + 4'd3;
                end
            end
            work = {work[4*DIGITS-2:0], bin[i]};
        end
        bcd = work;
    end

endmodule

// File: rtl/count_updn.sv
// -----------------------------------------------------------------------------
// count_updn
//   Up/down counter stepped by the 1 Hz tick, with synchronous load (clamped to
//   MAXVAL), wrap or saturate at the limits, and a one-cycle carry/borrow pulse.
//   Optional decimal view of the count, enabled by defining COUNT_UPDN_BCD_EN;
//   without it bcd is tied to zero and no converter is built.
//
//   Parameters: WIDTH (2..16), MAXVAL (1..2**WIDTH-1), DIGITS (10**DIGITS > MAXVAL)
//   Ports:
//     clk_1hz   in   count clock, rising edge
//     rst       in   asynchronous reset, active low
//     en        in   step enable
//     up        in   direction (see count_pkg::dir_e)
//     sat       in   limit mode (see count_pkg::mode_e)
//     load      in   synchronous load strobe, beats en
//     load_val  in   value to load, clamped to MAXVAL
//     count     out  registered count, always 0..MAXVAL
//     carry     out  registered one-cycle pulse after a wrap in either direction
//     at_limit  out  count at the limit for the current direction (combinational)
//     bcd       out  decimal digits of count, digit 0 in bcd[3:0]
// -----------------------------------------------------------------------------
module count_updn
    import count_pkg::*;
#(
    parameter int WIDTH  = 8,
    parameter int MAXVAL = 255,
    parameter int DIGITS = 3
) (
    input  logic                clk_1hz,
    input  logic                rst,
    input  logic                en,
    input  logic                up,
    input  logic                sat,
    input  logic                load,
    input  logic [WIDTH-1:0]    load_val,
    output logic [WIDTH-1:0]    count,
    output logic                carry,
    output logic                at_limit,
    output logic [4*DIGITS-1:0] bcd
);

    // One spare bit so the +1 at the top of a 2**WIDTH-1 range cannot alias.
    localparam logic [WIDTH:0] MAX_EXT = (WIDTH + 1)'(MAXVAL);

    logic [WIDTH:0] count_ext;
    logic [WIDTH:0] load_ext;
    logic [WIDTH:0] count_next;
    logic           carry_next;
    logic           unused_msb;

    assign count_ext = {1'b0, count};
    assign load_ext  = {1'b0, load_val};

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path
        // through the if/else tree can leave one unassigned and infer a latch.
        count_next = count_ext;
        carry_next = 1'b0;
        if (load) begin
            count_next = (load_ext > MAX_EXT) ? MAX_EXT : load_ext;
        end else if (en) begin
            if (dir_e'(up) == DIR_UP) begin
                if (count_ext < MAX_EXT) begin
                    count_next = count_ext + 1'b1;
                end else if (mode_e'(sat) == MODE_WRAP) begin
                    count_next = '0;
                    carry_next = 1'b1;
                end
            end else begin
                if (count_ext != '0) begin
                    count_next = count_ext - 1'b1;
                end else if (mode_e'(sat) == MODE_WRAP) begin
                    count_next = MAX_EXT;
                    carry_next = 1'b1;
                end
            end
        end
    end

    // The top bit is never set: count_next is bounded by MAX_EXT.
    assign unused_msb = count_next[WIDTH];

    always_ff @(posedge clk_1hz or negedge rst) begin
        if (!rst) begin
            count <= '0;
            carry <= 1'b0;
        end else begin
            count <= count_next[WIDTH-1:0];
            carry <= carry_next;
        end
    end

    assign at_limit = (dir_e'(up) == DIR_UP) ? (count_ext == MAX_EXT)
                                             : (count_ext == '0);

`ifdef COUNT_UPDN_BCD_EN
    bin2bcd_n #(
        .WIDTH  (WIDTH),
        .DIGITS (DIGITS)
    ) u_bin2bcd (
        .bin (count),
        .bcd (bcd)
    );
`else
    assign bcd = '0;
`endif

endmodule

// File: tb/tb_count_updn.sv
// -----------------------------------------------------------------------------
// tb_count_updn
//   Four count_updn instances (MAXVAL 255, 59, 99 and 1) share one set of
//   inputs; each vector names the instance whose outputs it checks. Vectors
//   that switch instance start with a load so the checked state is known.
// -----------------------------------------------------------------------------
module tb_count_updn;
    import count_pkg::*;

    logic       clk_1hz;
    logic       rst;
    logic       en;
    logic       up;
    logic       sat;
    logic       load;
    logic [7:0] load_val;

    logic [7:0]  count_a, count_b, count_c;
    logic [1:0]  count_d;
    logic        carry_a, carry_b, carry_c, carry_d;
    logic        lim_a, lim_b, lim_c, lim_d;
    logic [11:0] bcd_a;
    logic [7:0]  bcd_b, bcd_c;
    logic [3:0]  bcd_d;

    int n_checks = 0;
    int n_errors = 0;

    count_updn #(.WIDTH(8), .MAXVAL(255), .DIGITS(digits_for(255))) u_a (
        .clk_1hz(clk_1hz), .rst(rst), .en(en), .up(up), .sat(sat), .load(load),
        .load_val(load_val), .count(count_a), .carry(carry_a), .at_limit(lim_a), .bcd(bcd_a)
    );
    count_updn #(.WIDTH(8), .MAXVAL(59), .DIGITS(digits_for(59))) u_b (
        .clk_1hz(clk_1hz), .rst(rst), .en(en), .up(up), .sat(sat), .load(load),
        .load_val(load_val), .count(count_b), .carry(carry_b), .at_limit(lim_b), .bcd(bcd_b)
    );
    count_updn #(.WIDTH(8), .MAXVAL(99), .DIGITS(digits_for(99))) u_c (
        .clk_1hz(clk_1hz), .rst(rst), .en(en), .up(up), .sat(sat), .load(load),
        .load_val(load_val), .count(count_c), .carry(carry_c), .at_limit(lim_c), .bcd(bcd_c)
    );
    count_updn #(.WIDTH(2), .MAXVAL(1), .DIGITS(digits_for(1))) u_d (
        .clk_1hz(clk_1hz), .rst(rst), .en(en), .up(up), .sat(sat), .load(load),
        .load_val(load_val[1:0]), .count(count_d), .carry(carry_d), .at_limit(lim_d), .bcd(bcd_d)
    );

    initial clk_1hz = 1'b0;
    always #5 clk_1hz = ~clk_1hz;

    typedef struct {
        int         sel;
        logic       ld;
        logic       en;
        logic       up;
        logic       sat;
        logic [7:0] lv;
        logic [7:0] exp_cnt;
        logic       exp_carry;
        logic       exp_lim;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference decimal view computed by division, independent of the converter.
    function automatic logic [15:0] exp_bcd(input logic [7:0] v);
        logic [15:0] r;
        int          x;
        r = '0;
`ifdef COUNT_UPDN_BCD_EN
        x = int'(v);
        for (int d = 0; d < 3; d++) begin
            r[4*d +: 4] = 4'(x % 10);
            x = x / 10;
        end
`else
        x = int'(v);
        if (x < 0) r = 16'hffff;
`endif
        return r;
    endfunction

    task automatic step(input logic ld_i, input logic en_i, input logic up_i,
                        input logic sat_i, input logic [7:0] lv_i);
        @(negedge clk_1hz);
        load     = ld_i;
        en       = en_i;
        up       = up_i;
        sat      = sat_i;
        load_val = lv_i;
        @(posedge clk_1hz);
        #1;
    endtask

    task automatic check_inst(input string tag, input int sel, input logic [7:0] ec,
                              input logic ecar, input logic elim);
        logic [7:0]  c;
        logic        cy;
        logic        lm;
        logic [15:0] b;
        case (sel)
            0:       begin c = count_a;        cy = carry_a; lm = lim_a; b = 16'(bcd_a); end
            1:       begin c = count_b;        cy = carry_b; lm = lim_b; b = 16'(bcd_b); end
            2:       begin c = count_c;        cy = carry_c; lm = lim_c; b = 16'(bcd_c); end
            default: begin c = 8'(count_d);    cy = carry_d; lm = lim_d; b = 16'(bcd_d); end
        endcase
        check({tag, " count"},    16'(c),  16'(ec));
        check({tag, " carry"},    16'(cy), 16'(ecar));
        check({tag, " at_limit"}, 16'(lm), 16'(elim));
        check({tag, " bcd"},      b,       exp_bcd(ec));
    endtask

    initial begin
        // sel, ld, en, up, sat, load_val, exp count, exp carry, exp at_limit
        // MAXVAL 255: wrap at the top
        vecs.push_back('{0, 1'b1, 1'b0, 1'b1, 1'b0, 8'd254, 8'd254, 1'b0, 1'b0});
        vecs.push_back('{0, 1'b0, 1'b1, 1'b1, 1'b0, 8'd0,   8'd255, 1'b0, 1'b1});
        vecs.push_back('{0, 1'b0, 1'b1, 1'b1, 1'b0, 8'd0,   8'd0,   1'b1, 1'b0});
        vecs.push_back('{0, 1'b0, 1'b1, 1'b1, 1'b0, 8'd0,   8'd1,   1'b0, 1'b0});
        // MAXVAL 59: saturate up, then count down, then saturate at 0
        vecs.push_back('{1, 1'b1, 1'b0, 1'b1, 1'b1, 8'd58,  8'd58,  1'b0, 1'b0});
        vecs.push_back('{1, 1'b0, 1'b1, 1'b1, 1'b1, 8'd0,   8'd59,  1'b0, 1'b1});
        vecs.push_back('{1, 1'b0, 1'b1, 1'b1, 1'b1, 8'd0,   8'd59,  1'b0, 1'b1});
        vecs.push_back('{1, 1'b0, 1'b1, 1'b1, 1'b1, 8'd0,   8'd59,  1'b0, 1'b1});
        vecs.push_back('{1, 1'b0, 1'b1, 1'b0, 1'b1, 8'd0,   8'd58,  1'b0, 1'b0});
        vecs.push_back('{1, 1'b0, 1'b1, 1'b0, 1'b1, 8'd0,   8'd57,  1'b0, 1'b0});
        vecs.push_back('{1, 1'b1, 1'b0, 1'b0, 1'b1, 8'd0,   8'd0,   1'b0, 1'b1});
        vecs.push_back('{1, 1'b0, 1'b1, 1'b0, 1'b1, 8'd0,   8'd0,   1'b0, 1'b1});
        // MAXVAL 99: down-wrap, one-cycle carry, load clamp
        vecs.push_back('{2, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0,   8'd0,   1'b0, 1'b1});
        vecs.push_back('{2, 1'b0, 1'b1, 1'b0, 1'b0, 8'd0,   8'd99,  1'b1, 1'b0});
        vecs.push_back('{2, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0,   8'd99,  1'b0, 1'b0});
        vecs.push_back('{2, 1'b1, 1'b0, 1'b0, 1'b0, 8'd200, 8'd99,  1'b0, 1'b0});
        vecs.push_back('{2, 1'b1, 1'b0, 1'b1, 1'b0, 8'd200, 8'd99,  1'b0, 1'b1});
        // MAXVAL 1: alternating direction gives carry on consecutive cycles
        vecs.push_back('{3, 1'b1, 1'b0, 1'b1, 1'b0, 8'd0,   8'd0,   1'b0, 1'b0});
        vecs.push_back('{3, 1'b0, 1'b1, 1'b1, 1'b0, 8'd0,   8'd1,   1'b0, 1'b1});
        vecs.push_back('{3, 1'b0, 1'b1, 1'b1, 1'b0, 8'd0,   8'd0,   1'b1, 1'b0});
        vecs.push_back('{3, 1'b0, 1'b1, 1'b0, 1'b0, 8'd0,   8'd1,   1'b1, 1'b0});
        vecs.push_back('{3, 1'b0, 1'b1, 1'b1, 1'b0, 8'd0,   8'd0,   1'b1, 1'b0});
        vecs.push_back('{3, 1'b0, 1'b0, 1'b1, 1'b0, 8'd0,   8'd0,   1'b0, 1'b0});
        // MAXVAL 255: load beats en, then park at 37
        vecs.push_back('{0, 1'b1, 1'b1, 1'b1, 1'b0, 8'd5,   8'd5,   1'b0, 1'b0});
        vecs.push_back('{0, 1'b1, 1'b0, 1'b1, 1'b0, 8'd37,  8'd37,  1'b0, 1'b0});

        // Reset state
        rst      = 1'b0;
        en       = 1'b0;
        up       = 1'b0;
        sat      = 1'b0;
        load     = 1'b0;
        load_val = '0;
        #12;
        check_inst("reset dn", 0, 8'd0, 1'b0, 1'b1);
        up = 1'b1;
        #1;
        check_inst("reset up", 0, 8'd0, 1'b0, 1'b0);

        // Release, then 10 up-steps; first edge is an ordinary step
        @(negedge clk_1hz);
        rst = 1'b1;
        for (int i = 1; i <= 10; i++) begin
            step(1'b0, 1'b1, 1'b1, 1'b0, 8'd0);
            check_inst($sformatf("run10 step %0d", i), 0, 8'(i), 1'b0, 1'b0);
        end

        // Vector table
        for (int i = 0; i < vecs.size(); i++) begin
            step(vecs[i].ld, vecs[i].en, vecs[i].up, vecs[i].sat, vecs[i].lv);
            check_inst($sformatf("vec %0d", i), vecs[i].sel, vecs[i].exp_cnt,
                       vecs[i].exp_carry, vecs[i].exp_lim);
        end

        // Asynchronous reset while mid-count and while carry is high
        step(1'b0, 1'b1, 1'b1, 1'b0, 8'd0);
        check_inst("pre-rst a", 0, 8'd38, 1'b0, 1'b0);
        check_inst("pre-rst d", 3, 8'd0, 1'b1, 1'b0);
        @(negedge clk_1hz);
        en = 1'b0;
        #2;
        rst = 1'b0;
        #1;
        check_inst("async rst a", 0, 8'd0, 1'b0, 1'b0);
        check_inst("async rst d", 3, 8'd0, 1'b0, 1'b0);
        @(negedge clk_1hz);
        rst = 1'b1;
        step(1'b0, 1'b1, 1'b0, 1'b0, 8'd0);
        check_inst("post-rst c", 2, 8'd99, 1'b1, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/count_updn.md
# count_updn

Parametrised up/down counter; the next-generation replacement for the fixed 1-byte demo counter on the study board. It counts at the 1 Hz tick in either direction, supports synchronous load, wrap or saturate at a programmable limit, and a one-cycle carry/borrow pulse. It optionally provides a decimal (BCD) view of the count for the 7-segment digit muxes. It sits between the 1 Hz pulse divider and the LED/hexdigit display logic.

## Interface
- WIDTH, 8: count register width in bits (2..16)
- MAXVAL, 255: terminal count, 1 ≤ MAXVAL ≤ 2**WIDTH−1
- DIGITS, 3: number of BCD digits; 10**DIGITS > MAXVAL is required
- clk_1hz  in  1  count clock; all state changes on its rising edge
- rst  in  1  reset, asynchronous, active-low
- en  in  1  step enable, sampled at the rising edge of clk_1hz
- up  in  1  direction: 1 = increment, 0 = decrement
- sat  in  1  limit mode: 1 = saturate, 0 = wrap
- load  in  1  synchronous load strobe
- load_val  in  WIDTH  load value
- count  out  WIDTH  current count (registered)
- carry  out  1  one-cycle pulse marking a wrap in either direction (registered)
- at_limit  out  1  high while count == MAXVAL (up) or count == 0 (down); combinational from count and up
- bcd  out  4*DIGITS  decimal digits of count; digit 0 = bcd[3:0]

## Operation
- Reset (rst low, asynchronous): count = 0, carry = 0. at_limit and bcd follow from count = 0.
- Per rising edge, priority: load > en step > hold.
- load = 1: count ← min(load_val, MAXVAL); carry ← 0. en is ignored that cycle.
- en = 1, up = 1:
  - count < MAXVAL: count ← count + 1, carry ← 0.
  - count == MAXVAL, sat = 0: count ← 0, carry ← 1.
  - count == MAXVAL, sat = 1: count holds, carry ← 0.
- en = 1, up = 0:
  - count > 0: count ← count − 1, carry ← 0.
  - count == 0, sat = 0: count ← MAXVAL, carry ← 1.
  - count == 0, sat = 1: count holds, carry ← 0.
- en = 0, load = 0: count holds, carry ← 0.
- Arithmetic is done at WIDTH+1 bits. The count never exceeds MAXVAL, including after a load or a change of up or sat.
- Direction or mode may change on any cycle. The new value applies at the next edge with no pipeline hazard.

## Timing
- Step latency: 1 clk_1hz edge from sampled en to new count.
- carry is high for exactly one clk_1hz period, the cycle after the wrap edge. Back-to-back wraps (e.g. MAXVAL = 1, continuous en) give carry high on consecutive cycles.
- bcd is combinational from count and valid in the same cycle as count.
- Reset asserted mid-count forces count = 0 and carry = 0 immediately. Release is synchronised externally. The first edge after release behaves as a normal step.

## Configuration
- COUNT_UPDN_BCD_EN:
  - Defined: the bcd output is driven by the double-dabble converter over WIDTH bits and DIGITS digits.
  - Not defined: bcd is tied to 0 and no converter logic is instantiated. count, carry and at_limit are unaffected.

## Structure
- Shared package count_pkg: direction and mode encodings (DIR_UP, DIR_DN, MODE_WRAP, MODE_SAT) and a function giving the digit count for a MAXVAL, used by instantiating tops.
- One sub-module, bin2bcd_n: parametrised (WIDTH, DIGITS) combinational double-dabble. It is instantiated only under COUNT_UPDN_BCD_EN.
- Counter core, limit compare and carry register live in count_updn itself.

## Test plan
- Reset then 10 edges, with WIDTH=8, MAXVAL=255, en=1, up=1, sat=0 → count = 10, bcd = 0x010, carry never set.
- load_val = 254, then 3 up-steps → count goes 255, 0, 1. carry is high only during the cycle count = 0. at_limit is high while count = 255.
- MAXVAL=59, sat=1, load 58, 3 up-steps → count goes 59, 59, 59; carry stays 0. Then up=0 for 2 steps → 58, 57.
- Down-wrap with MAXVAL=99, sat=0, count=0, up=0, step → count = 99, carry pulses 1 cycle, bcd = 0x099. load_val = 200 with load=1 → count = 99 (clamped).
- load and en both high, load_val = 5 → count = 5 (load wins). rst pulsed low mid-count at 37 → count = 0 and carry = 0 asynchronously, before the next edge.
- Build without COUNT_UPDN_BCD_EN → bcd = 0 at all counts; count and carry sequences are identical to the scenarios above.
